// File: rtl/calc_bin2bcd.sv
// Sequential binary-to-BCD converter (shift-and-add-3), one input bit per clock.
// Start/busy/done handshake; bcd holds the last complete result until the next done.
module calc_bin2bcd #(
  parameter int WIDTH  = 8,
  parameter int DIGITS = 3
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  input  logic [WIDTH-1:0]      bin,
  output logic [4*DIGITS-1:0]   bcd,
  output logic                  busy,
  output logic                  done
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } state_t;

  localparam int CW = $clog2(WIDTH + 1);

  state_t              state;
  state_t              state_nxt;
  logic [WIDTH-1:0]    shreg;
  logic [4*DIGITS-1:0] scratch;
  logic [4*DIGITS-1:0] adj;
  logic [4*DIGITS-1:0] scratch_nxt;
  logic [CW-1:0]       count;
  logic                last_shift;

  assign last_shift = (count == CW'(WIDTH - 1));

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values of its peers, independent of block ordering.
  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  // NOTE: each always_comb assigns its outputs a default first, so no path
  // through the block leaves a signal unassigned and infers a latch.
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (start) state_nxt = SHIFT;
      SHIFT:   if (last_shift) state_nxt = DONE;
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    busy = (state == SHIFT);
    done = (state == DONE);
  end

  // Add 3 to every digit >= 5 so the following shift carries correctly into the next decade.
  always_comb begin
    adj = scratch;
    for (int k = 0; k < DIGITS; k++) begin
      if (scratch[4*k +: 4] >= 4'd5) adj[4*k +: 4] = scratch[4*k +: 4] + 4'd3;
    end
  end

  assign scratch_nxt = {adj[4*DIGITS-2:0], shreg[WIDTH-1]};

  // NOTE: all datapath registers are small flops, so they are cleared on reset;
  // bcd is loaded on the final shift so it is valid in the same cycle done is high.
  always_ff @(posedge clk) begin
    if (rst) begin
      shreg   <= '0;
      scratch <= '0;
      count   <= '0;
      bcd     <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            shreg   <= bin;
            scratch <= '0;
            count   <= '0;
          end
        end
        SHIFT: begin
          scratch <= scratch_nxt;
          shreg   <= {shreg[WIDTH-2:0], 1'b0};
          count   <= count + CW'(1);
          if (last_shift) bcd <= scratch_nxt;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_calc_bin2bcd.sv
// Self-checking bench for calc_bin2bcd: directed vector table, full 0..255 sweep,
// and hand-written sequences for ignored start, mid-conversion reset and back-to-back starts.
module tb_calc_bin2bcd;

  logic        clk = 1'b0;
  logic        rst;
  logic        start;
  logic [7:0]  bin;
  logic [11:0] bcd;
  logic        busy;
  logic        done;

  int passed = 0;
  int total  = 0;

  calc_bin2bcd #(.WIDTH(8), .DIGITS(3)) dut (
    .clk   (clk),
    .rst   (rst),
    .start (start),
    .bin   (bin),
    .bcd   (bcd),
    .busy  (busy),
    .done  (done)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [7:0]  bin;
    logic [11:0] exp;
  } vec_t;

  vec_t vecs[12];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act === exp) passed++;
    else $display("FAIL %s: got %0h, expected %0h", name, act, exp);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [11:0] to_bcd(input int v);
    return {4'(v / 100), 4'((v / 10) % 10), 4'(v % 10)};
  endfunction

  // Issues a start for v, perturbs bin after acceptance, and waits (bounded) for done.
  // lat is the cycle count from the accepting edge to the done cycle.
  task automatic run_conv(input logic [7:0] v, output logic [11:0] res,
                          output int busy_n, output int lat, output bit seen);
    start = 1'b1;
    bin   = v;
    step();
    start  = 1'b0;
    bin    = ~v;
    lat    = 1;
    busy_n = 0;
    while (!done && lat <= 20) begin
      if (busy) busy_n++;
      step();
      lat++;
    end
    seen = done;
    res  = bcd;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [11:0] res;
    int          busy_n;
    int          lat;
    bit          seen;
    int          dn;
    int          last_done;
    logic [11:0] cap;

    vecs[0]  = '{8'd0,   12'h000};
    vecs[1]  = '{8'd1,   12'h001};
    vecs[2]  = '{8'd9,   12'h009};
    vecs[3]  = '{8'd10,  12'h010};
    vecs[4]  = '{8'd37,  12'h037};
    vecs[5]  = '{8'd99,  12'h099};
    vecs[6]  = '{8'd100, 12'h100};
    vecs[7]  = '{8'd128, 12'h128};
    vecs[8]  = '{8'd199, 12'h199};
    vecs[9]  = '{8'd200, 12'h200};
    vecs[10] = '{8'd254, 12'h254};
    vecs[11] = '{8'd255, 12'h255};

    rst   = 1'b1;
    start = 1'b0;
    bin   = 8'd0;
    step();
    step();
    check("reset busy", 32'(busy), 32'd0);
    check("reset done", 32'(done), 32'd0);
    check("reset bcd",  32'(bcd),  32'h000);
    rst = 1'b0;
    step();

    // Zero input: latency and result.
    run_conv(8'd0, res, busy_n, lat, seen);
    check("zero done seen", 32'(seen), 32'd1);
    check("zero latency",   32'(lat),  32'd9);
    check("zero bcd",       32'(res),  32'h000);
    check("zero busy cycles", 32'(busy_n), 32'd8);
    step();

    // Max input: busy width and single-cycle done.
    run_conv(8'd255, res, busy_n, lat, seen);
    check("max done seen",   32'(seen),   32'd1);
    check("max bcd",         32'(res),    32'h255);
    check("max busy cycles", 32'(busy_n), 32'd8);
    step();
    check("max done width",  32'(done),   32'd0);
    check("max bcd held",    32'(bcd),    32'h255);
    check("max idle busy",   32'(busy),   32'd0);

    // Directed vector table.
    for (int i = 0; i < 12; i++) begin
      run_conv(vecs[i].bin, res, busy_n, lat, seen);
      check($sformatf("vec%0d done seen", i), 32'(seen), 32'd1);
      check($sformatf("vec%0d bcd bin=%0d", i, vecs[i].bin), 32'(res), 32'(vecs[i].exp));
      check($sformatf("vec%0d latency", i), 32'(lat), 32'd9);
      step();
    end

    // Full sweep against an arithmetic digit model.
    for (int v = 0; v < 256; v++) begin
      run_conv(8'(v), res, busy_n, lat, seen);
      check($sformatf("sweep bin=%0d", v), 32'(res), 32'(to_bcd(v)));
      step();
    end

    // start during SHIFT is ignored: one done with the first value only.
    start = 1'b1;
    bin   = 8'd37;
    step();
    start = 1'b0;
    dn    = 0;
    cap   = '0;
    for (int i = 1; i <= 25; i++) begin
      if (i == 3) begin start = 1'b1; bin = 8'd200; end
      if (i == 4) begin start = 1'b0; bin = 8'd0; end
      if (done) begin dn++; cap = bcd; end
      step();
    end
    check("ignored start done count", 32'(dn),  32'd1);
    check("ignored start bcd",        32'(cap), 32'h037);

    // Reset in the 4th SHIFT cycle aborts the conversion.
    start = 1'b1;
    bin   = 8'd200;
    step();
    start = 1'b0;
    step();
    step();
    step();
    check("pre-abort busy", 32'(busy), 32'd1);
    rst = 1'b1;
    step();
    rst = 1'b0;
    check("abort busy", 32'(busy), 32'd0);
    check("abort done", 32'(done), 32'd0);
    check("abort bcd",  32'(bcd),  32'h000);
    dn = 0;
    for (int i = 0; i < 15; i++) begin
      if (done) dn++;
      step();
    end
    check("abort no done", 32'(dn), 32'd0);
    run_conv(8'd42, res, busy_n, lat, seen);
    check("after abort bcd", 32'(res), 32'h042);
    step();

    // start held high: one conversion every 10 cycles.
    start     = 1'b1;
    bin       = 8'd123;
    dn        = 0;
    last_done = -1;
    for (int i = 1; i <= 30; i++) begin
      step();
      if (done) begin
        dn++;
        check($sformatf("held bcd #%0d", dn), 32'(bcd), 32'h123);
        if (last_done >= 0) check($sformatf("held period #%0d", dn), 32'(i - last_done), 32'd10);
        last_done = i;
      end
    end
    start = 1'b0;
    check("held done count", 32'(dn), 32'd3);
    step();
    check("held final idle", 32'(busy), 32'd0);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
